// File: rtl/top_entity.sv
// top_entity: two-input stream runtime monitor.
// The HLC timestamps input events and periodic ticks into an event queue.
// The LLC pops one event at a time and evaluates three output streams:
//   o0 = a + b      (when both inputs are new)
//   o1 = o1' + o0   (with o0)
//   o2 = o1         (on ticks, after the same event's o1 update)
// Optional debug visibility is enabled with the macro TOP_ENTITY_DEBUG_EN.
module top_entity #(
   parameter int unsigned QUEUE_DEPTH   = 4,
   parameter int unsigned PERIOD_CYCLES = 250
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [63:0] input_0,
   input  logic               new_input_0,
   input  logic signed [63:0] input_1,
   input  logic               new_input_1,
   output logic signed [63:0] output_0,
   output logic               output_0_aktv,
   output logic signed [63:0] output_1,
   output logic               output_1_aktv,
   output logic signed [63:0] output_2,
   output logic               output_2_aktv,
   output logic signed [63:0] llc_tag,
   output logic               llc_to_pop,
   output logic               llc_is_valid_event,
   output logic               q_push_valid,
   output logic               q_pop_valid
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned TS_W   = 64;
   localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
   localparam int unsigned PER_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

   typedef struct packed {
      logic [TS_W-1:0]   ts;
      logic              n0;
      logic [DATA_W-1:0] a;
      logic              n1;
      logic [DATA_W-1:0] b;
      logic              tick;
   } event_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL0 = 2'd1,
      ST_EVAL1 = 2'd2
   } state_t;

   // Power-up values equal reset values so the block runs without rst.
   logic [TS_W-1:0]   ts_q    = '0;
   logic [PER_W-1:0]  per_q   = '0;
   logic [PTR_W-1:0]  wr_q    = '0;
   logic [PTR_W-1:0]  rd_q    = '0;
   logic [CNT_W-1:0]  cnt_q   = '0;
   state_t            state_q = ST_IDLE;
   state_t            state_d;
   event_t            cur_q   = '0;
   logic [DATA_W-1:0] o0_q    = '0;
   logic [TS_W-1:0]   tag_q   = '0;
   logic [DATA_W-1:0] out0_q  = '0;
   logic [DATA_W-1:0] out1_q  = '0;
   logic [DATA_W-1:0] out2_q  = '0;
   logic              aktv0_q = 1'b0;
   logic              aktv1_q = 1'b0;
   logic              aktv2_q = 1'b0;

   event_t            mem [QUEUE_DEPTH];

   logic              tick;
   logic              ev_valid;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              cur_both;
   logic [DATA_W-1:0] o1_next;
   event_t            ev_in;

   // Wrapping queue pointer increment (depth need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // HLC: tick detection, event assembly and push acceptance.
   always_comb begin
      tick     = (per_q == PER_W'(PERIOD_CYCLES - 1));
      ev_valid = en & (new_input_0 | new_input_1 | tick);
      full     = (cnt_q == CNT_W'(QUEUE_DEPTH));
      empty    = (cnt_q == '0);
      ev_in    = '{ts: ts_q, n0: new_input_0, a: input_0,
                   n1: new_input_1, b: input_1, tick: tick};
      push     = ev_valid & (~full | pop);
   end

   // LLC next-state logic; a pop happens only from IDLE with a non-empty queue.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en && !empty) begin
               pop     = 1'b1;
               state_d = ST_EVAL0;
            end
         end
         ST_EVAL0: if (en) state_d = ST_EVAL1;
         ST_EVAL1: if (en) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // LLC state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Timestamp and period counters advance together on every enabled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q  <= '0;
         per_q <= '0;
      end else if (en) begin
         ts_q  <= ts_q + TS_W'(1);
         per_q <= tick ? '0 : per_q + PER_W'(1);
      end
   end

   // Queue storage; contents are don't-care while the entry is unoccupied.
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= ev_in;
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign cur_both = cur_q.n0 & cur_q.n1;
   assign o1_next  = out1_q + o0_q;

   // LLC datapath: latch on pop, o0 in EVAL0, o1/o2 and pulses in EVAL1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q   <= '0;
         tag_q   <= '0;
         o0_q    <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
         aktv0_q <= 1'b0;
         aktv1_q <= 1'b0;
         aktv2_q <= 1'b0;
      end else begin
         aktv0_q <= 1'b0;
         aktv1_q <= 1'b0;
         aktv2_q <= 1'b0;
         if (pop) begin
            cur_q <= mem[rd_q];
            tag_q <= mem[rd_q].ts;
         end
         if (en && state_q == ST_EVAL0 && cur_both) begin
            o0_q <= cur_q.a + cur_q.b;
         end
         if (en && state_q == ST_EVAL1) begin
            if (cur_both) begin
               out0_q  <= o0_q;
               out1_q  <= o1_next;
               aktv0_q <= 1'b1;
               aktv1_q <= 1'b1;
            end
            if (cur_q.tick) begin
               out2_q  <= cur_both ? o1_next : out1_q;
               aktv2_q <= 1'b1;
            end
         end
      end
   end

   // Verdict outputs; pulses are suppressed while the block is disabled.
   assign output_0      = out0_q;
   assign output_1      = out1_q;
   assign output_2      = out2_q;
   assign output_0_aktv = aktv0_q & en;
   assign output_1_aktv = aktv1_q & en;
   assign output_2_aktv = aktv2_q & en;

`ifdef TOP_ENTITY_DEBUG_EN
   // Live debug view of the LLC and queue handshake.
   assign llc_tag            = tag_q;
   assign llc_to_pop         = (state_q == ST_IDLE);
   assign llc_is_valid_event = (state_q != ST_IDLE);
   assign q_push_valid       = push;
   assign q_pop_valid        = pop;
`else
   // Debug ports tied off; the tag register is kept but not observed.
   logic unused_tag;
   assign unused_tag         = ^tag_q;
   assign llc_tag            = '0;
   assign llc_to_pop         = 1'b0;
   assign llc_is_valid_event = 1'b0;
   assign q_push_valid       = 1'b0;
   assign q_pop_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_top_entity.sv
// Testbench for top_entity: randomized stimulus against a transaction-level
// reference model (event queue + LLC busy countdown), plus directed checks.
module tb_top_entity;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PERIOD = 250;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en  = 1'b0;
   logic signed [63:0] input_0 = '0;
   logic               new_input_0 = 1'b0;
   logic signed [63:0] input_1 = '0;
   logic               new_input_1 = 1'b0;
   logic signed [63:0] output_0, output_1, output_2, llc_tag;
   logic               output_0_aktv, output_1_aktv, output_2_aktv;
   logic               llc_to_pop, llc_is_valid_event, q_push_valid, q_pop_valid;

   top_entity #(.QUEUE_DEPTH(DEPTH), .PERIOD_CYCLES(PERIOD)) dut (
      .clk(clk), .rst(rst), .en(en),
      .input_0(input_0), .new_input_0(new_input_0),
      .input_1(input_1), .new_input_1(new_input_1),
      .output_0(output_0), .output_0_aktv(output_0_aktv),
      .output_1(output_1), .output_1_aktv(output_1_aktv),
      .output_2(output_2), .output_2_aktv(output_2_aktv),
      .llc_tag(llc_tag), .llc_to_pop(llc_to_pop),
      .llc_is_valid_event(llc_is_valid_event),
      .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] ts;
      bit          n0;
      logic [63:0] a;
      bit          n1;
      logic [63:0] b;
      bit          tick;
   } mev_t;

   // Reference model state.
   mev_t        mq[$];
   mev_t        m_cur;
   int          m_busy = 0;     // cycles of evaluation remaining, 0 = idle
   logic [63:0] m_ts = '0;
   logic [63:0] m_tag = '0;
   logic [63:0] m_o0 = '0, m_o1 = '0, m_o2 = '0;
   bit          m_ak0, m_ak1, m_ak2;
   bit          m_last_push;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check combinational handshake, advance
   // model at the edge, check registered outputs.
   task automatic step(input bit r, input bit e, input bit n0, input logic [63:0] a,
                       input bit n1, input logic [63:0] b);
      bit   pop_m, push_m, tick_m, ev_m, both;
      mev_t ev;
      @(negedge clk);
      rst = r; en = e; new_input_0 = n0; input_0 = a; new_input_1 = n1; input_1 = b;
      #1;
      tick_m = ((m_ts % 64'(PERIOD)) == 64'(PERIOD - 1));
      pop_m  = e && (m_busy == 0) && (mq.size() > 0);
      ev_m   = e && (n0 || n1 || tick_m);
      push_m = ev_m && ((mq.size() < DEPTH) || pop_m);
      m_last_push = push_m && !r;
      check("aktv0_gate", 64'(output_0_aktv), 64'(m_ak0 & e));
      check("aktv1_gate", 64'(output_1_aktv), 64'(m_ak1 & e));
      check("aktv2_gate", 64'(output_2_aktv), 64'(m_ak2 & e));
`ifdef TOP_ENTITY_DEBUG_EN
      check("q_push_valid", 64'(q_push_valid), 64'(push_m));
      check("q_pop_valid", 64'(q_pop_valid), 64'(pop_m));
`else
      check("q_push_tied", 64'(q_push_valid), 64'(0));
      check("q_pop_tied", 64'(q_pop_valid), 64'(0));
`endif
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_busy = 0; m_ts = '0; m_tag = '0;
         m_o0 = '0; m_o1 = '0; m_o2 = '0;
         m_ak0 = 0; m_ak1 = 0; m_ak2 = 0;
      end else begin
         m_ak0 = 0; m_ak1 = 0; m_ak2 = 0;
         if (e) begin
            if (m_busy == 1) begin
               both = m_cur.n0 && m_cur.n1;
               if (both) begin
                  m_o0 = m_cur.a + m_cur.b;
                  m_o1 = m_o1 + m_o0;
                  m_ak0 = 1; m_ak1 = 1;
               end
               if (m_cur.tick) begin
                  m_o2 = m_o1;
                  m_ak2 = 1;
               end
               m_busy = 0;
            end else if (m_busy == 2) begin
               m_busy = 1;
            end
            if (pop_m) begin
               m_cur  = mq.pop_front();
               m_tag  = m_cur.ts;
               m_busy = 2;
            end
            if (push_m) begin
               ev = '{ts: m_ts, n0: n0, a: a, n1: n1, b: b, tick: tick_m};
               mq.push_back(ev);
            end
            m_ts = m_ts + 64'd1;
         end
      end
      #1;
      check("output_0", output_0, m_o0);
      check("output_1", output_1, m_o1);
      check("output_2", output_2, m_o2);
      check("output_0_aktv", 64'(output_0_aktv), 64'(m_ak0 & e));
      check("output_1_aktv", 64'(output_1_aktv), 64'(m_ak1 & e));
      check("output_2_aktv", 64'(output_2_aktv), 64'(m_ak2 & e));
`ifdef TOP_ENTITY_DEBUG_EN
      check("llc_tag", llc_tag, m_tag);
      check("llc_to_pop", 64'(llc_to_pop), 64'(m_busy == 0));
      check("llc_is_valid_event", 64'(llc_is_valid_event), 64'(m_busy != 0));
`else
      check("llc_tag_tied", llc_tag, 64'(0));
      check("llc_to_pop_tied", 64'(llc_to_pop), 64'(0));
`endif
   endtask

   task automatic idle();
      step(0, 1, 0, '0, 0, '0);
   endtask

   task automatic idle_until(input logic [63:0] target);
      while (m_ts < target) idle();
   endtask

   // Absolute watchdog so a broken DUT cannot hang the run.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] exp1 [4];
      logic [63:0] burst_sum;
      logic [63:0] ra, rb;
      exp1[0] = 64'd2; exp1[1] = 64'd6; exp1[2] = 64'd12; exp1[3] = 64'd20;

      // Reset then idle.
      step(1, 1, 0, '0, 0, '0);
      step(1, 1, 0, '0, 0, '0);
      for (int i = 0; i < 100; i++) idle();
      check("idle_out0", output_0, 64'(0));
      check("idle_out1", output_1, 64'(0));
`ifdef TOP_ENTITY_DEBUG_EN
      check("idle_to_pop", 64'(llc_to_pop), 64'(1));
`endif

      // First tick at cycle 249 with no inputs: o2 = 0 with a pulse.
      idle_until(64'd249);
      idle();
      for (int i = 0; i < 3; i++) idle();
      check("tick0_aktv2", 64'(output_2_aktv), 64'(1));
      check("tick0_out2", output_2, 64'(0));

      // Inputs (k,k) 500 cycles apart.
      for (int k = 1; k <= 4; k++) begin
         idle_until(64'(300 + 500 * (k - 1)));
         step(0, 1, 1, 64'(k), 1, 64'(k));
         for (int i = 0; i < 3; i++) idle();
         check("seq_aktv0", 64'(output_0_aktv), 64'(1));
         check("seq_out0", output_0, 64'(2 * k));
         check("seq_out1", output_1, exp1[k-1]);
         if (k == 1) begin
            idle_until(64'd510);
            check("tick1_out2", output_2, 64'(2));
         end
      end

      // Single new input: popped and evaluated, no activation.
      idle_until(64'd1900);
      step(0, 1, 1, 64'd5, 0, '0);
      for (int i = 0; i < 3; i++) idle();
      check("single_aktv0", 64'(output_0_aktv), 64'(0));
      check("single_out0", output_0, 64'(8));
      check("single_out1", output_1, 64'(20));

      // Burst of 10 consecutive dual events overflows the queue.
      idle_until(64'd2010);
      burst_sum = m_o1;
      for (int i = 0; i < 10; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         step(0, 1, 1, ra, 1, rb);
         if (m_last_push) burst_sum = burst_sum + ra + rb;
      end
      for (int i = 0; i < 40; i++) idle();
      check("burst_out1_sum", output_1, burst_sum);

      // Enable low: inputs ignored, values hold.
      for (int i = 0; i < 5; i++) step(0, 0, 1, 64'd7, 1, 64'd9);
      for (int i = 0; i < 5; i++) idle();

      // Randomized traffic with occasional enable drops and resets.
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 2) == 0, {$urandom, $urandom},
              $urandom_range(0, 2) == 0, {$urandom, $urandom});
      end

      // Reset while the LLC is in its first evaluation cycle.
      for (int i = 0; i < 10; i++) idle();
      step(0, 1, 1, 64'd11, 1, 64'd22);
      for (int i = 0; i < 10 && m_busy != 2; i++) idle();
      check("reach_eval0", 64'(m_busy), 64'(2));
      step(1, 1, 0, '0, 0, '0);
      check("rst_out0", output_0, 64'(0));
      check("rst_out1", output_1, 64'(0));
      check("rst_out2", output_2, 64'(0));
      check("rst_aktv0", 64'(output_0_aktv), 64'(0));
      for (int i = 0; i < 6; i++) idle();
      check("rst_discard_out0", output_0, 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
